// File: rtl/bias3_delta_gen.sv
// Output-layer bias delta generator: sums per-output errors over a minibatch,
// scales by 2^-LR_SHIFT with floor rounding, saturates to 16 bits, issues one update.
module bias3_delta_gen #(
  parameter int BATCH    = 4,
  parameter int LR_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               err_valid,
  output logic               err_ready,
  input  logic signed [15:0] err_1,
  input  logic signed [15:0] err_2,
  input  logic signed [15:0] err_3,
  input  logic signed [15:0] err_4,
  input  logic               flush,
  output logic [3:0]         ctrl,
  output logic [3:0]         step,
  output logic signed [15:0] deltab3_1,
  output logic signed [15:0] deltab3_2,
  output logic signed [15:0] deltab3_3,
  output logic signed [15:0] deltab3_4
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCALE = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [15:0] BATCH_C = 16'(BATCH);

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    logic signed [15:0] r;
    if (v > 32'sd32767) begin
      r = 16'sh7fff;
    end else if (v < -32'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  state_t             state_r;
  logic signed [31:0] acc_r   [4];
  logic signed [15:0] delta_r [4];
  logic [15:0]        count_r;
  logic [3:0]         ctrl_r;
  logic [3:0]         step_r;

  logic signed [15:0] err_s [4];
  logic               accept_s;
  logic [15:0]        count_next_s;

  assign err_s[0] = err_1;
  assign err_s[1] = err_2;
  assign err_s[2] = err_3;
  assign err_s[3] = err_4;

  // Sample acceptance and the count including this cycle's sample
  always_comb begin
    accept_s = err_valid && (state_r == ACCUM) && !rst;
    if (accept_s) begin
      count_next_s = count_r + 16'd1;
    end else begin
      count_next_s = count_r;
    end
  end

  // Accumulate / scale / issue sequencing with registered update command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACCUM;
      count_r <= 16'd0;
      ctrl_r  <= 4'b0000;
      step_r  <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        acc_r[i]   <= 32'sd0;
        delta_r[i] <= 16'sd0;
      end
    end else begin
      case (state_r)
        ACCUM: begin
          ctrl_r <= 4'b0000;
          if (accept_s) begin
            count_r <= count_next_s;
            for (int i = 0; i < 4; i++) begin
              acc_r[i] <= acc_r[i] + {{16{err_s[i][15]}}, err_s[i]};
            end
          end
          if ((count_next_s == BATCH_C) || (flush && (count_next_s != 16'd0))) begin
            state_r <= SCALE;
          end
        end
        SCALE: begin
          for (int i = 0; i < 4; i++) begin
            delta_r[i] <= sat16(acc_r[i] >>> LR_SHIFT);
          end
          ctrl_r  <= 4'b0011;
          state_r <= ISSUE;
        end
        ISSUE: begin
          ctrl_r  <= 4'b0000;
          count_r <= 16'd0;
          step_r  <= step_r + 4'd1;
          for (int i = 0; i < 4; i++) begin
            acc_r[i] <= 32'sd0;
          end
          state_r <= ACCUM;
        end
        default: begin
          ctrl_r  <= 4'b0000;
          state_r <= ACCUM;
        end
      endcase
    end
  end

  // A reset arriving during ISSUE must suppress the command in that same cycle
  assign ctrl      = rst ? 4'b0000 : ctrl_r;
  assign err_ready = (state_r == ACCUM);
  assign step      = step_r;
  assign deltab3_1 = delta_r[0];
  assign deltab3_2 = delta_r[1];
  assign deltab3_3 = delta_r[2];
  assign deltab3_4 = delta_r[3];

endmodule

// File: tb/tb_bias3_delta_gen.sv
// Bench for bias3_delta_gen: two instances (LR_SHIFT 4 and 0) share stimulus;
// a model pushes expected deltas per batch and each issue pops and compares them.
module tb_bias3_delta_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               err_valid = 1'b0;
  logic               flush = 1'b0;
  logic signed [15:0] e [4];
  logic               rdy_a, rdy_b;
  logic [3:0]         ctrl_a, ctrl_b, step_a, step_b;
  logic signed [15:0] oa [4];
  logic signed [15:0] ob [4];

  int errors = 0;
  int checks = 0;

  logic [63:0] qa [$];
  logic [63:0] qb [$];
  logic [3:0]  qs [$];
  int          sum_m [4];
  int          cnt_m = 0;
  logic [3:0]  step_m = 4'd0;

  bias3_delta_gen #(.BATCH(4), .LR_SHIFT(4)) dut_a (
    .clk(clk), .rst(rst), .err_valid(err_valid), .err_ready(rdy_a),
    .err_1(e[0]), .err_2(e[1]), .err_3(e[2]), .err_4(e[3]), .flush(flush),
    .ctrl(ctrl_a), .step(step_a),
    .deltab3_1(oa[0]), .deltab3_2(oa[1]), .deltab3_3(oa[2]), .deltab3_4(oa[3])
  );

  bias3_delta_gen #(.BATCH(4), .LR_SHIFT(0)) dut_b (
    .clk(clk), .rst(rst), .err_valid(err_valid), .err_ready(rdy_b),
    .err_1(e[0]), .err_2(e[1]), .err_3(e[2]), .err_4(e[3]), .flush(flush),
    .ctrl(ctrl_b), .step(step_b),
    .deltab3_1(ob[0]), .deltab3_2(ob[1]), .deltab3_3(ob[2]), .deltab3_4(ob[3])
  );

  function automatic logic [15:0] exp_delta(input int s, input int sh);
    int q;
    q = s >>> sh;
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) sum_m[i] = 0;
    cnt_m = 0;
    step_m = 4'd0;
    qa.delete(); qb.delete(); qs.delete();
  endtask

  task automatic close_batch();
    logic [63:0] pa, pb;
    pa = 64'd0; pb = 64'd0;
    step_m = step_m + 4'd1;
    for (int i = 0; i < 4; i++) begin
      pa[16*i +: 16] = exp_delta(sum_m[i], 4);
      pb[16*i +: 16] = exp_delta(sum_m[i], 0);
      sum_m[i] = 0;
    end
    qa.push_back(pa); qb.push_back(pb); qs.push_back(step_m);
    cnt_m = 0;
  endtask

  // Present one sample (retrying while not ready); the accept happens at the next posedge.
  task automatic drive_sample(input int v0, input int v1, input int v2, input int v3, input bit fl);
    bit done;
    int v [4];
    done = 1'b0;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int t = 0; t < 10 && !done; t++) begin
      @(negedge clk);
      err_valid = 1'b1;
      flush = fl;
      for (int i = 0; i < 4; i++) e[i] = 16'(v[i]);
      if (rdy_a) begin
        done = 1'b1;
        for (int i = 0; i < 4; i++) sum_m[i] += v[i];
        cnt_m++;
        if (cnt_m == 4 || fl) close_batch();
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout: sample not accepted within 10 cycles (ready=%0b)", rdy_a);
    end
  endtask

  // Drops the inputs, then waits (bounded) for the update command.
  task automatic wait_issue(output bit got, output int cyc);
    got = 1'b0; cyc = 0;
    for (int t = 1; t <= 20 && !got; t++) begin
      @(negedge clk);
      if (t == 1) begin err_valid = 1'b0; flush = 1'b0; end
      if (ctrl_a == 4'b0011) begin got = 1'b1; cyc = t; end
    end
  endtask

  task automatic test_reset();
    err_valid = 1'b1;
    for (int i = 0; i < 4; i++) e[i] = 16'sd1000;
    repeat (3) @(negedge clk);
    checks++;
    if (ctrl_a !== 4'd0 || ctrl_b !== 4'd0) begin errors++; $display("FAIL reset_ctrl: got %0d/%0d want 0", ctrl_a, ctrl_b); end
    checks++;
    if (step_a !== 4'd0 || step_b !== 4'd0) begin errors++; $display("FAIL reset_step: got %0d/%0d want 0", step_a, step_b); end
    checks++;
    if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", rdy_a); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (oa[i] !== 16'sd0 || ob[i] !== 16'sd0) begin errors++; $display("FAIL reset_delta%0d: got %0d/%0d want 0", i+1, oa[i], ob[i]); end
    end
    rst = 1'b0;
    err_valid = 1'b0;
  endtask

  task automatic test_floor();
    bit got; int cyc; logic [63:0] pa, pb; logic [3:0] ps;
    logic signed [15:0] want [4];
    want[0] = 16'sd4; want[1] = -16'sd4; want[2] = 16'sd0; want[3] = -16'sd1;
    repeat (4) drive_sample(16, -16, 1, -1, 1'b0);
    wait_issue(got, cyc);
    checks++;
    if (!got || qa.size() == 0) begin
      errors++; $display("FAIL floor_issue: got=%0b queued=%0d", got, qa.size());
    end else begin
      pa = qa.pop_front(); pb = qb.pop_front(); ps = qs.pop_front();
      checks++;
      if (cyc != 2) begin errors++; $display("FAIL floor_latency: got %0d cycles want 2", cyc); end
      for (int i = 0; i < 4; i++) begin
        checks += 3;
        if (oa[i] !== want[i]) begin errors++; $display("FAIL floor_const%0d: got %0d want %0d", i+1, oa[i], want[i]); end
        if (oa[i] !== pa[16*i +: 16]) begin errors++; $display("FAIL floor_a%0d: got %0d want %0d", i+1, oa[i], $signed(pa[16*i +: 16])); end
        if (ob[i] !== pb[16*i +: 16]) begin errors++; $display("FAIL floor_b%0d: got %0d want %0d", i+1, ob[i], $signed(pb[16*i +: 16])); end
      end
      @(negedge clk);
      checks++;
      if (step_a !== ps || step_b !== ps || ctrl_a !== 4'd0 || rdy_a !== 1'b1) begin
        errors++; $display("FAIL floor_after: step=%0d ctrl=%0d ready=%0b want step=%0d ctrl=0 ready=1", step_a, ctrl_a, rdy_a, ps);
      end
    end
  endtask

  task automatic test_saturation();
    bit got; int cyc; logic [63:0] pa, pb; logic [3:0] ps;
    repeat (4) drive_sample(32767, -32768, 1000, -7, 1'b0);
    wait_issue(got, cyc);
    checks++;
    if (!got || qa.size() == 0) begin
      errors++; $display("FAIL sat_issue: got=%0b queued=%0d", got, qa.size());
    end else begin
      pa = qa.pop_front(); pb = qb.pop_front(); ps = qs.pop_front();
      checks++;
      if (ob[0] !== 16'sd32767 || ob[1] !== -16'sd32768) begin
        errors++; $display("FAIL sat_clamp: got %0d,%0d want 32767,-32768", ob[0], ob[1]);
      end
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (oa[i] !== pa[16*i +: 16]) begin errors++; $display("FAIL sat_a%0d: got %0d want %0d", i+1, oa[i], $signed(pa[16*i +: 16])); end
        if (ob[i] !== pb[16*i +: 16]) begin errors++; $display("FAIL sat_b%0d: got %0d want %0d", i+1, ob[i], $signed(pb[16*i +: 16])); end
      end
      @(negedge clk);
      checks++;
      if (step_a !== ps) begin errors++; $display("FAIL sat_step: got %0d want %0d", step_a, ps); end
    end
  endtask

  task automatic test_flush();
    bit got; int cyc; int n3; logic [63:0] pa, pb; logic [3:0] ps;
    drive_sample(5, 3, -3, 0, 1'b0);
    drive_sample(5, 3, -3, 0, 1'b1);
    wait_issue(got, cyc);
    checks++;
    if (!got || qa.size() == 0) begin
      errors++; $display("FAIL flush_issue: got=%0b queued=%0d", got, qa.size());
    end else begin
      pa = qa.pop_front(); pb = qb.pop_front(); ps = qs.pop_front();
      checks += 2;
      if (cyc != 2) begin errors++; $display("FAIL flush_latency: got %0d cycles want 2", cyc); end
      if (ob[0] !== 16'sd10) begin errors++; $display("FAIL flush_sum: got %0d want 10", ob[0]); end
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (oa[i] !== pa[16*i +: 16]) begin errors++; $display("FAIL flush_a%0d: got %0d want %0d", i+1, oa[i], $signed(pa[16*i +: 16])); end
        if (ob[i] !== pb[16*i +: 16]) begin errors++; $display("FAIL flush_b%0d: got %0d want %0d", i+1, ob[i], $signed(pb[16*i +: 16])); end
      end
      @(negedge clk);
      checks++;
      if (step_a !== ps) begin errors++; $display("FAIL flush_step: got %0d want %0d", step_a, ps); end
    end
    // Idle flush with nothing accumulated must not start an update
    n3 = 0;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (ctrl_a == 4'b0011 || ctrl_b == 4'b0011) n3++;
    end
    checks += 2;
    if (n3 != 0) begin errors++; $display("FAIL idle_flush: got %0d issue cycles want 0", n3); end
    if (step_a !== step_m) begin errors++; $display("FAIL idle_flush_step: got %0d want %0d", step_a, step_m); end
  endtask

  task automatic test_backpressure();
    int v; int issues; bit scale_next; logic [63:0] pa, pb; logic [3:0] ps;
    v = 100; issues = 0; scale_next = 1'b0;
    for (int t = 0; t < 40 && issues < 2; t++) begin
      @(negedge clk);
      if (scale_next) begin
        scale_next = 1'b0;
        checks++;
        if (rdy_a !== 1'b0) begin errors++; $display("FAIL bp_scale_ready: got %0b want 0", rdy_a); end
      end
      if (ctrl_a == 4'b0011) begin
        issues++;
        checks++;
        if (rdy_a !== 1'b0) begin errors++; $display("FAIL bp_issue_ready: got %0b want 0", rdy_a); end
        if (qa.size() != 0) begin
          pa = qa.pop_front(); pb = qb.pop_front(); ps = qs.pop_front();
          for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (oa[i] !== pa[16*i +: 16]) begin errors++; $display("FAIL bp_a%0d: got %0d want %0d", i+1, oa[i], $signed(pa[16*i +: 16])); end
            if (ob[i] !== pb[16*i +: 16]) begin errors++; $display("FAIL bp_b%0d: got %0d want %0d", i+1, ob[i], $signed(pb[16*i +: 16])); end
          end
        end else begin
          checks++; errors++; $display("FAIL bp_unexpected_issue: issue %0d with empty queue", issues);
        end
      end
      if (issues < 2) begin
        err_valid = 1'b1;
        for (int i = 0; i < 4; i++) e[i] = 16'(v + i*1000);
        if (rdy_a) begin
          for (int i = 0; i < 4; i++) sum_m[i] += v + i*1000;
          v++;
          cnt_m++;
          if (cnt_m == 4) begin close_batch(); scale_next = 1'b1; end
        end
      end else begin
        err_valid = 1'b0;
      end
    end
    err_valid = 1'b0;
    checks++;
    if (issues != 2 || v != 108) begin errors++; $display("FAIL bp_count: got %0d issues %0d samples want 2 issues 8 samples", issues, v-100); end
  endtask

  task automatic test_reset_mid();
    bit got; int cyc; int n3; logic [63:0] pa, pb; logic [3:0] ps;
    repeat (4) drive_sample(2000, -2000, 300, 77, 1'b0);
    @(negedge clk);
    rst = 1'b1; err_valid = 1'b0;
    n3 = 0;
    checks++;
    if (rdy_a !== 1'b0) begin errors++; $display("FAIL rm_scale_ready: got %0b want 0", rdy_a); end
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (ctrl_a == 4'b0011 || ctrl_b == 4'b0011) n3++;
      if (t == 1) rst = 1'b0;
    end
    clear_model();
    checks += 2;
    if (n3 != 0) begin errors++; $display("FAIL rm_ctrl: got %0d issue cycles want 0", n3); end
    if (step_a !== 4'd0 || step_b !== 4'd0) begin errors++; $display("FAIL rm_step: got %0d/%0d want 0", step_a, step_b); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (oa[i] !== 16'sd0 || ob[i] !== 16'sd0) begin errors++; $display("FAIL rm_delta%0d: got %0d/%0d want 0", i+1, oa[i], ob[i]); end
    end
    drive_sample(160, -33, 7, 9000, 1'b0);
    drive_sample(16, -1, 7, 9000, 1'b0);
    drive_sample(-48, 0, 7, 9000, 1'b0);
    drive_sample(32, -15, 7, 9000, 1'b0);
    wait_issue(got, cyc);
    checks++;
    if (!got || qa.size() == 0) begin
      errors++; $display("FAIL rm_issue: got=%0b queued=%0d", got, qa.size());
    end else begin
      pa = qa.pop_front(); pb = qb.pop_front(); ps = qs.pop_front();
      for (int i = 0; i < 4; i++) begin
        checks += 2;
        if (oa[i] !== pa[16*i +: 16]) begin errors++; $display("FAIL rm_a%0d: got %0d want %0d", i+1, oa[i], $signed(pa[16*i +: 16])); end
        if (ob[i] !== pb[16*i +: 16]) begin errors++; $display("FAIL rm_b%0d: got %0d want %0d", i+1, ob[i], $signed(pb[16*i +: 16])); end
      end
      @(negedge clk);
      checks++;
      if (step_a !== 4'd1) begin errors++; $display("FAIL rm_step_after: got %0d want 1", step_a); end
    end
  endtask

  task automatic test_step_wrap();
    bit got; int cyc; logic [63:0] pa, pb; logic [3:0] ps;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    clear_model();
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 4; k++) drive_sample(b*97 - 700 + k*13, -b*211 + k, b*b*50, k*4000 - 8000, 1'b0);
      wait_issue(got, cyc);
      checks++;
      if (!got || qa.size() == 0) begin
        errors++; $display("FAIL wrap_issue%0d: got=%0b queued=%0d", b, got, qa.size());
      end else begin
        pa = qa.pop_front(); pb = qb.pop_front(); ps = qs.pop_front();
        for (int i = 0; i < 4; i++) begin
          checks += 2;
          if (oa[i] !== pa[16*i +: 16]) begin errors++; $display("FAIL wrap%0d_a%0d: got %0d want %0d", b, i+1, oa[i], $signed(pa[16*i +: 16])); end
          if (ob[i] !== pb[16*i +: 16]) begin errors++; $display("FAIL wrap%0d_b%0d: got %0d want %0d", b, i+1, ob[i], $signed(pb[16*i +: 16])); end
        end
        @(negedge clk);
        checks++;
        if (step_a !== ps || step_b !== ps) begin errors++; $display("FAIL wrap_step%0d: got %0d/%0d want %0d", b, step_a, step_b, ps); end
        repeat (2) @(negedge clk);
        checks++;
        if ({oa[3], oa[2], oa[1], oa[0]} !== pa || {ob[3], ob[2], ob[1], ob[0]} !== pb) begin
          errors++; $display("FAIL wrap_hold%0d: got %h/%h want %h/%h", b, {oa[3], oa[2], oa[1], oa[0]}, {ob[3], ob[2], ob[1], ob[0]}, pa, pb);
        end
      end
    end
    checks++;
    if (step_a !== 4'd0) begin errors++; $display("FAIL wrap_final: got %0d want 0", step_a); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin e[i] = 16'sd0; sum_m[i] = 0; end
    test_reset();
    test_floor();
    test_saturation();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_step_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
